a5_stream_feeder: RTL

- Upstream stage of the A5/1 image encryptor.
- Serializes a 64-bit session key and a 22-bit frame number onto the encryptor's `in` line, then holds `in` low for the majority-clock mix period.
- Then streams image pixels, MSB first, one bit per clock onto the encryptor's `ip_img` line.
- Accepts pixels over a valid/ready byte handshake and flags when each image bit is valid, so downstream keystream consumption can be gated.

---
 rtl/a5_stream_feeder.sv | 345 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/a5_stream_feeder.sv
// a5_stream_feeder
//   Upstream stage of the A5/1 image encryptor. After an accepted start it
//   shifts the session key (LSB first) and then the frame number (LSB first)
//   onto key_bit, holds key_bit low for the mix period, and then streams image
//   pixels MSB first, one bit per clock, onto img_bit.
//
// Build option:
//   A5_FEED_SKID_EN  defined   : two-entry pixel buffer, registered pix_ready.
//                    undefined : single holding register, pix_ready derived
//                                from internal state only.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   start          begin request, honoured only in IDLE
//   session_key    key, latched on accepted start
//   frame_num      frame number, latched on accepted start
//   pix_data/pix_valid/pix_ready  pixel byte handshake
//   key_bit        serial load bit (encryptor `in`)
//   img_bit        serial image bit (encryptor `ip_img`)
//   img_bit_valid  img_bit carries a real pixel bit
//   phase          0=IDLE 1=KEY 2=FRAME 3=MIX 4=STREAM
//   pix_count      pixels fully shifted out since start
//   underrun_cnt   saturating count of stalled STREAM cycles
//   busy           phase != IDLE
//   done           one-cycle pulse at end of image
module a5_stream_feeder #(
  parameter int unsigned KEY_W      = 64,
  parameter int unsigned FRAME_W    = 22,
  parameter int unsigned MIX_CYCLES = 100,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned NUM_PIX    = 65536
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KEY_W-1:0]   session_key,
  input  logic [FRAME_W-1:0] frame_num,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic               key_bit,
  output logic               img_bit,
  output logic               img_bit_valid,
  output logic [2:0]         phase,
  output logic [15:0]        pix_count,
  output logic [15:0]        underrun_cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEY    = 3'd1,
    S_FRAME  = 3'd2,
    S_MIX    = 3'd3,
    S_STREAM = 3'd4
  } state_t;

  localparam int unsigned MAX_KF  = (KEY_W > FRAME_W) ? KEY_W : FRAME_W;
  localparam int unsigned CNT_MAX = (MAX_KF > MIX_CYCLES) ? MAX_KF : MIX_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = (PIX_W > 1) ? $clog2(PIX_W) : 1;

  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(PIX_W - 1);
  localparam logic [16:0]      NUM_PIX_C  = 17'(NUM_PIX);

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [KEY_W-1:0]   key_sr_q, key_sr_n;
  logic [FRAME_W-1:0] frame_sr_q, frame_sr_n;
  logic               key_bit_q, key_bit_n;
  logic               img_bit_q, img_bit_n;
  logic               img_valid_q, img_valid_n;
  logic [PIX_W-1:0]   cur_sh_q, cur_sh_n;
  logic [BIT_W-1:0]   bit_idx_q, bit_idx_n;
  logic [15:0]        pix_cnt_q, pix_cnt_n;
  logic [15:0]        under_q, under_n;
  logic               done_q, done_n;
  logic               busy_q, busy_n;

  // Buffer interface shared by both buffer variants.
  logic               head_valid;
  logic [PIX_W-1:0]   head_data;
  logic               accept;
  logic               boundary;
  logic               pop;
  logic               push;
  logic               bypass;
  logic               clear_buf;
  logic [PIX_W-1:0]   load_data;
  logic               last_bit;
  logic               terminal;

  assign accept    = pix_valid & pix_ready;
  assign last_bit  = img_valid_q && (bit_idx_q == BIT_LAST);
  assign terminal  = ({1'b0, pix_cnt_q} + 17'd1) == NUM_PIX_C;
  assign load_data = head_valid ? head_data : pix_data;

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    key_sr_n    = key_sr_q;
    frame_sr_n  = frame_sr_q;
    key_bit_n   = 1'b0;
    img_bit_n   = img_bit_q;
    img_valid_n = img_valid_q;
    cur_sh_n    = cur_sh_q;
    bit_idx_n   = bit_idx_q;
    pix_cnt_n   = pix_cnt_q;
    under_n     = under_q;
    done_n      = 1'b0;
    boundary    = 1'b0;
    pop         = 1'b0;
    bypass      = 1'b0;
    clear_buf   = 1'b0;

    case (state_q)
      S_IDLE: begin
        img_bit_n   = 1'b0;
        img_valid_n = 1'b0;
        if (start) begin
          state_n    = S_KEY;
          cnt_n      = '0;
          key_bit_n  = session_key[0];
          key_sr_n   = session_key >> 1;
          frame_sr_n = frame_num;
          pix_cnt_n  = '0;
          under_n    = '0;
        end
      end
      S_KEY: begin
        if (cnt_q == KEY_LAST) begin
          state_n    = S_FRAME;
          cnt_n      = '0;
          key_bit_n  = frame_sr_q[0];
          frame_sr_n = frame_sr_q >> 1;
        end else begin
          cnt_n     = cnt_q + 1'b1;
          key_bit_n = key_sr_q[0];
          key_sr_n  = key_sr_q >> 1;
        end
      end
      S_FRAME: begin
        if (cnt_q == FRAME_LAST) begin
          state_n = S_MIX;
          cnt_n   = '0;
        end else begin
          cnt_n      = cnt_q + 1'b1;
          key_bit_n  = frame_sr_q[0];
          frame_sr_n = frame_sr_q >> 1;
        end
      end
      S_MIX: begin
        img_bit_n   = 1'b0;
        img_valid_n = 1'b0;
        if (cnt_q == MIX_LAST) begin
          // The first pixel is loaded on the same edge that enters STREAM.
          state_n  = S_STREAM;
          cnt_n    = '0;
          boundary = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (img_valid_q && !last_bit) begin
          img_bit_n = cur_sh_q[PIX_W-1];
          cur_sh_n  = cur_sh_q << 1;
          bit_idx_n = bit_idx_q + 1'b1;
        end else if (last_bit && terminal) begin
          if (pix_cnt_q != '1) pix_cnt_n = pix_cnt_q + 16'd1;
          done_n      = 1'b1;
          state_n     = S_IDLE;
          img_bit_n   = 1'b0;
          img_valid_n = 1'b0;
          clear_buf   = 1'b1;
        end else begin
          if (img_valid_q) pix_cnt_n = pix_cnt_q + 16'd1;
          boundary = 1'b1;
        end
      end
      default: begin
        state_n     = S_IDLE;
        img_bit_n   = 1'b0;
        img_valid_n = 1'b0;
        clear_buf   = 1'b1;
      end
    endcase

    // Pixel boundary: take the buffered pixel, else one arriving this edge
    // goes straight into the shifter, else stall.
    if (boundary) begin
      if (head_valid || accept) begin
        img_bit_n   = load_data[PIX_W-1];
        cur_sh_n    = load_data << 1;
        bit_idx_n   = '0;
        img_valid_n = 1'b1;
        pop         = head_valid;
        bypass      = !head_valid;
      end else begin
        img_bit_n   = 1'b0;
        img_valid_n = 1'b0;
        if (under_q != '1) under_n = under_q + 16'd1;
      end
    end

    push   = accept && !bypass && !clear_buf;
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      key_sr_q    <= '0;
      frame_sr_q  <= '0;
      key_bit_q   <= 1'b0;
      img_bit_q   <= 1'b0;
      img_valid_q <= 1'b0;
      cur_sh_q    <= '0;
      bit_idx_q   <= '0;
      pix_cnt_q   <= '0;
      under_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      key_sr_q    <= key_sr_n;
      frame_sr_q  <= frame_sr_n;
      key_bit_q   <= key_bit_n;
      img_bit_q   <= img_bit_n;
      img_valid_q <= img_valid_n;
      cur_sh_q    <= cur_sh_n;
      bit_idx_q   <= bit_idx_n;
      pix_cnt_q   <= pix_cnt_n;
      under_q     <= under_n;
      done_q      <= done_n;
      busy_q      <= busy_n;
    end
  end

`ifdef A5_FEED_SKID_EN
  logic [PIX_W-1:0] buf0_q, buf0_n;
  logic [PIX_W-1:0] buf1_q, buf1_n;
  logic [1:0]       fill_q, fill_n;
  logic             ready_q, ready_n;

  assign head_valid = (fill_q != 2'd0);
  assign head_data  = buf0_q;
  assign pix_ready  = ready_q;

  always_comb begin
    buf0_n = buf0_q;
    buf1_n = buf1_q;
    fill_n = fill_q;
    if (clear_buf) begin
      fill_n = '0;
    end else begin
      case ({pop, push})
        2'b10: begin
          buf0_n = buf1_q;
          fill_n = fill_q - 2'd1;
        end
        2'b01: begin
          if (fill_q == 2'd0) buf0_n = pix_data;
          else                buf1_n = pix_data;
          fill_n = fill_q + 2'd1;
        end
        2'b11: begin
          if (fill_q == 2'd1) begin
            buf0_n = pix_data;
          end else begin
            buf0_n = buf1_q;
            buf1_n = pix_data;
          end
        end
        default: ;
      endcase
    end
    ready_n = (fill_n < 2'd2) && ((state_n == S_MIX) || (state_n == S_STREAM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf0_q  <= '0;
      buf1_q  <= '0;
      fill_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      buf0_q  <= buf0_n;
      buf1_q  <= buf1_n;
      fill_q  <= fill_n;
      ready_q <= ready_n;
    end
  end
`else
  logic [PIX_W-1:0] hold_q, hold_n;
  logic             hold_full_q, hold_full_n;

  assign head_valid = hold_full_q;
  assign head_data  = hold_q;
  // The last-bit term lets a new pixel land in the register on the same
  // edge the held one moves into the shifter.
  assign pix_ready  = ((state_q == S_MIX) || (state_q == S_STREAM)) &&
                      (!hold_full_q || ((state_q == S_STREAM) && last_bit));

  always_comb begin
    hold_n      = hold_q;
    hold_full_n = hold_full_q;
    if (clear_buf) begin
      hold_full_n = 1'b0;
    end else begin
      if (pop) hold_full_n = 1'b0;
      if (push) begin
        hold_n      = pix_data;
        hold_full_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_n;
      hold_full_q <= hold_full_n;
    end
  end
`endif

  assign key_bit       = key_bit_q;
  assign img_bit       = img_bit_q;
  assign img_bit_valid = img_valid_q;
  assign phase         = state_q;
  assign pix_count     = pix_cnt_q;
  assign underrun_cnt  = under_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
